// File: rtl/cp0_ctrl.sv
// MIPS-style CP0 controller: SR/Cause/EPC, interrupt and exception arbitration, eret.
// Optional read-only PrId register at address 15 when CP0_PRID_EN is defined.
module cp0_ctrl #(
    parameter logic [31:0] EPC_RST = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic        exc_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hwint,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
`ifdef CP0_PRID_EN
    localparam logic [4:0]  ADDR_PRID = 5'd15;
    localparam logic [31:0] PRID_VAL  = 32'h4255_4141;
`endif

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic        int_req;
    logic        exc_req;

    // A victim in a delay slot restarts at its branch so the branch re-executes.
    function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic in_bd);
        return in_bd ? (pc - 32'd4) : pc;
    endfunction

    assign int_req = (|(ip & im)) & ie & ~exl;
    assign exc_req = exc_in & ~exl;
    assign req     = int_req | exc_req;
    assign epc_out = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= EPC_RST;
        end else begin
            ip <= hwint;
            if (req) begin
                exl      <= 1'b1;
                bd       <= bd_in;
                exc_code <= int_req ? 5'd0 : exc_code_in;
                epc      <= victim_epc(vpc, bd_in);
            end else begin
                if (en && cp0_addr == ADDR_SR) begin
                    im  <= cp0_wdata[15:10];
                    exl <= cp0_wdata[1];
                    ie  <= cp0_wdata[0];
                end
                if (en && cp0_addr == ADDR_EPC)
                    epc <= cp0_wdata;
                // eret wins over a same-cycle mtc0 to SR.EXL
                if (eret)
                    exl <= 1'b0;
            end
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = {16'b0, im, 8'b0, exl, ie};
            ADDR_CAUSE: cp0_rdata = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
            ADDR_EPC:   cp0_rdata = epc;
`ifdef CP0_PRID_EN
            ADDR_PRID:  cp0_rdata = PRID_VAL;
`endif
            default:    cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Vector-table bench for cp0_ctrl with a scoreboard queue of expected outputs.
module tb_cp0_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic        exc_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hwint;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

`ifdef CP0_PRID_EN
    localparam logic [31:0] PRID_EXP = 32'h4255_4141;
`else
    localparam logic [31:0] PRID_EXP = 32'h0;
`endif

    cp0_ctrl #(.EPC_RST(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .vpc(vpc),
        .bd_in(bd_in), .exc_in(exc_in), .exc_code_in(exc_code_in),
        .hwint(hwint), .eret(eret), .req(req), .epc_out(epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        eret;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] vpc;
        logic        bd;
        logic        exc;
        logic [4:0]  code;
        logic [5:0]  hw;
        logic        xreq;
        logic [31:0] xrdata;
        logic [31:0] xepc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic rst, input logic e, input logic er,
                                input logic [4:0] a, input logic [31:0] wd,
                                input logic [31:0] pc, input logic b, input logic x,
                                input logic [4:0] c, input logic [5:0] h,
                                input logic xr, input logic [31:0] xd, input logic [31:0] xe);
        vec_t t;
        t.rst = rst; t.en = e; t.eret = er; t.addr = a; t.wdata = wd; t.vpc = pc;
        t.bd = b; t.exc = x; t.code = c; t.hw = h;
        t.xreq = xr; t.xrdata = xd; t.xepc = xe;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        reset = t.rst; en = t.en; eret = t.eret; cp0_addr = t.addr;
        cp0_wdata = t.wdata; vpc = t.vpc; bd_in = t.bd; exc_in = t.exc;
        exc_code_in = t.code; hwint = t.hw;
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later, well before the rising edge.
    task automatic apply(input int idx, input vec_t t);
        vec_t g;
        bit   bad;
        @(negedge clk);
        drive(t);
        exp_q.push_back(t);
        #2;
        g   = exp_q.pop_front();
        bad = 1'b0;
        n_vec++;
        if (req !== g.xreq) begin
            $display("FAIL v%0d req: got %b want %b", idx, req, g.xreq);
            bad = 1'b1;
        end
        if (cp0_rdata !== g.xrdata) begin
            $display("FAIL v%0d rdata[a=%0d]: got %h want %h", idx, g.addr, cp0_rdata, g.xrdata);
            bad = 1'b1;
        end
        if (epc_out !== g.xepc) begin
            $display("FAIL v%0d epc_out: got %h want %h", idx, epc_out, g.xepc);
            bad = 1'b1;
        end
        if (bad) n_miss++;
    endtask

    initial begin
        int  lat;
        bit  seen;
        vec_t t;

        drive(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0));
        repeat (2) @(posedge clk);

        //          rst en er addr wdata         vpc           bd ex code hw  | req rdata        epc
        tbl.push_back(mk(1,0,0,12,0,            0,            0,0,0, 6'd0, 0,32'h0,        32'h3000));
        tbl.push_back(mk(0,0,0,13,0,            0,            0,0,0, 6'd0, 0,32'h0,        32'h3000));
        tbl.push_back(mk(0,0,0,14,0,            0,            0,0,0, 6'd0, 0,32'h3000,     32'h3000));
        tbl.push_back(mk(0,0,0,15,0,            0,            0,0,0, 6'd0, 0,PRID_EXP,     32'h3000));
        tbl.push_back(mk(0,0,0, 3,0,            0,            0,0,0, 6'd0, 0,32'h0,        32'h3000));
        // interrupt path: enable IM[10]/IE, then Timer0
        tbl.push_back(mk(0,1,0,12,32'h0000_0401,0,            0,0,0, 6'd0, 0,32'h0,        32'h3000));
        tbl.push_back(mk(0,0,0,12,0,            32'h3040,     0,0,0, 6'd1, 0,32'h401,      32'h3000));
        tbl.push_back(mk(0,0,0,13,0,            32'h3044,     0,0,0, 6'd1, 1,32'h400,      32'h3000));
        tbl.push_back(mk(0,0,0,12,0,            32'h3048,     0,0,0, 6'd1, 0,32'h403,      32'h3044));
        tbl.push_back(mk(0,0,0,13,0,            32'h304C,     0,0,0, 6'd1, 0,32'h400,      32'h3044));
        tbl.push_back(mk(0,0,1,12,0,            0,            0,0,0, 6'd1, 0,32'h403,      32'h3044));
        tbl.push_back(mk(0,0,0,12,0,            32'h3080,     0,0,0, 6'd1, 1,32'h401,      32'h3044));
        tbl.push_back(mk(0,0,0,14,0,            0,            0,0,0, 6'd0, 0,32'h3080,     32'h3080));
        tbl.push_back(mk(0,1,0,12,32'h0,        0,            0,0,0, 6'd0, 0,32'h403,      32'h3080));
        // overflow in a delay slot
        tbl.push_back(mk(0,0,0,12,0,            32'h3010,     1,1,12,6'd0, 1,32'h0,        32'h3080));
        tbl.push_back(mk(0,0,0,13,0,            0,            0,0,0, 6'd0, 0,32'h8000_0030,32'h300C));
        tbl.push_back(mk(0,0,0,12,0,            32'h3014,     0,1,4, 6'd0, 0,32'h2,        32'h300C));
        tbl.push_back(mk(0,1,0,13,32'hFFFF_FFFF,0,            0,0,0, 6'd0, 0,32'h8000_0030,32'h300C));
        tbl.push_back(mk(0,0,0,13,0,            0,            0,0,0, 6'd0, 0,32'h8000_0030,32'h300C));
        tbl.push_back(mk(0,0,1,12,0,            0,            0,0,0, 6'd0, 0,32'h2,        32'h300C));
        // exception and enabled interrupt together
        tbl.push_back(mk(0,1,0,12,32'h0000_1001,0,            0,0,0, 6'd4, 0,32'h0,        32'h300C));
        tbl.push_back(mk(0,0,0,12,0,            32'h3020,     0,1,10,6'd4, 1,32'h1001,     32'h300C));
        tbl.push_back(mk(0,0,0,13,0,            32'h3024,     0,1,10,6'd4, 0,32'h1000,     32'h3020));
        // mtc0 EPC colliding with a trap
        tbl.push_back(mk(0,0,1,12,0,            0,            0,0,0, 6'd0, 0,32'h1003,     32'h3020));
        tbl.push_back(mk(0,1,0,14,32'h3100,     32'h3030,     0,1,5, 6'd0, 1,32'h3020,     32'h3020));
        tbl.push_back(mk(0,0,0,14,0,            0,            0,0,0, 6'd0, 0,32'h3030,     32'h3030));
        tbl.push_back(mk(0,0,0,13,0,            0,            0,0,0, 6'd0, 0,32'h14,       32'h3030));
        // eret overridden by a same-cycle trap
        tbl.push_back(mk(0,0,1,12,0,            0,            0,0,0, 6'd0, 0,32'h1003,     32'h3030));
        tbl.push_back(mk(0,0,1,12,0,            32'h3050,     1,1,8, 6'd0, 1,32'h1001,     32'h3030));
        tbl.push_back(mk(0,0,0,12,0,            0,            0,0,0, 6'd0, 0,32'h1003,     32'h304C));
        tbl.push_back(mk(0,0,0,13,0,            0,            0,0,0, 6'd0, 0,32'h8000_0020,32'h304C));
        // reset beats mtc0/eret/req
        tbl.push_back(mk(1,1,1,14,32'h1234,     0,            0,1,12,6'd0, 0,32'h304C,     32'h304C));
        tbl.push_back(mk(0,0,0,14,0,            0,            0,0,0, 6'd0, 0,32'h3000,     32'h3000));
        tbl.push_back(mk(0,0,0,12,0,            0,            0,0,0, 6'd0, 0,32'h0,        32'h3000));
        tbl.push_back(mk(1,0,0,13,0,            32'h3060,     0,1,12,6'd0, 1,32'h0,        32'h3000));
        tbl.push_back(mk(0,0,0,13,0,            0,            0,0,0, 6'd0, 0,32'h0,        32'h3000));

        for (int i = 0; i < tbl.size(); i++)
            apply(i, tbl[i]);

        // Timer1 latency: hwint -> IP next edge -> req on the following cycle
        apply(100, mk(0,1,0,12,32'h0000_0801,0,0,0,0,6'd0, 0,32'h0,32'h3000));
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 6 && !seen; c++) begin
            @(negedge clk);
            drive(mk(0,0,0,13,0,32'h3070,0,0,0,6'd2, 0,0,0));
            #2;
            if (req === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        n_vec++;
        if (!seen || lat != 2) begin
            $display("FAIL timer1_latency: got %0d cycles (seen=%0b) want 2", lat, seen);
            n_miss++;
        end
        t = mk(0,0,0,13,0,32'h3074,0,0,0,6'd2, 0,32'h800,32'h3070);
        apply(101, t);
        apply(102, mk(0,0,0,12,0,0,0,0,0,6'd2, 0,32'h803,32'h3070));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL expose parameter: EPC_RST, 32'h0000_3000, EPC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: en  input  1  mtc0 write enable from M stage.
REQ-005 SHALL have port: cp0_addr  input  5  CP0 register number for mtc0/mfc0.
REQ-006 SHALL have port: cp0_wdata  input  32  mtc0 write data.
REQ-007 SHALL have port: cp0_rdata  output  32  mfc0 read data, combinational.
REQ-008 SHALL have port: vpc  input  32  PC of the victim instruction in M stage.
REQ-009 SHALL have port: bd_in  input  1  victim instruction sits in a branch delay slot.
REQ-010 SHALL have port: exc_in  input  1  synchronous exception reported by M stage.
REQ-011 SHALL have port: exc_code_in  input  5  ExcCode for exc_in (4 AdEL, 5 AdES, 8 Syscall, 10 RI, 12 Ov).
REQ-012 SHALL have port: hwint  input  6  hardware interrupt lines: [0] Timer0, [1] Timer1, [2] external interrupt.
REQ-013 SHALL have port: eret  input  1  eret retiring in M stage.
REQ-014 SHALL have port: req  output  1  flush pipeline and redirect fetch to handler 32'h0000_4180.
REQ-015 SHALL have port: epc_out  output  32  current EPC register, eret target.

Function
REQ-016 SHALL implement SR (12), Cause (13) and EPC (14); reads of other addresses SHALL return 0.
REQ-017 SHALL format SR reads as {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; unlisted bits SHALL read 0 and ignore writes.
REQ-018 SHALL format Cause reads as {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}; mtc0 to Cause SHALL have no effect.
REQ-019 SHALL latch Cause.IP <= hwint every cycle, independent of EXL and IM.
REQ-020 SHALL compute int_req = |(Cause.IP & SR.IM) & SR.IE & !SR.EXL combinationally from registered state.
REQ-021 SHALL compute exc_req = exc_in & !SR.EXL and req = int_req | exc_req, both combinational.
REQ-022 SHALL give interrupts priority: when both are present, ExcCode SHALL be 0 (Int).
REQ-023 SHALL on the cycle req=1 load at the next edge: EXL<=1, BD<=bd_in, ExcCode<=(int_req ? 0 : exc_code_in), EPC<=(bd_in ? vpc-4 : vpc).
REQ-024 SHALL ignore an mtc0 (en=1) issued in the same cycle as req=1.
REQ-025 SHALL clear EXL at the next edge when eret=1 and req=0; eret with req=1 SHALL be overridden by req.
REQ-026 SHALL apply mtc0 writes to SR/EPC at the next edge; cp0_rdata and epc_out SHALL reflect registered values only, with no write bypass.
REQ-027 SHALL keep one interrupt acceptance per EXL episode: req stays 0 while EXL=1 regardless of hwint.

Reset
REQ-028 SHALL on reset=1 at an edge set SR=0, Cause=0, EPC=EPC_RST; req SHALL therefore be 0 in the first cycle after reset.
REQ-029 SHALL give reset priority over req, eret and mtc0 in the same cycle.

Configuration
REQ-030 SHALL with CP0_PRID_EN defined implement read-only PrId (15) returning 32'h4255_4141; without it, address 15 SHALL read 0.

Verification
REQ-031 SHALL cover: reset, then mtc0 SR=32'h0000_0401, hwint=6'b000001 -> IP[10] set next cycle, req=1 the cycle after, ExcCode=0, EXL=1, EPC=vpc.
REQ-032 SHALL cover: exc_in=1, exc_code_in=12, bd_in=1, vpc=32'h0000_3010 -> req=1 same cycle; next cycle Cause=32'h8000_0030, EPC=32'h0000_300C.
REQ-033 SHALL cover: exc_in=1 and pending enabled interrupt in same cycle -> ExcCode=0 recorded, only one req cycle.
REQ-034 SHALL cover: EXL=1, hwint asserted -> req=0; eret=1 -> EXL=0 next cycle, req=1 the cycle after.
REQ-035 SHALL cover: mtc0 EPC=32'h0000_3100 with en=1 and req=1 same cycle -> EPC holds the trap value, not 32'h0000_3100; mtc0 Cause=32'hFFFF_FFFF -> Cause unchanged.
